// File: rtl/multiplier_controller.sv
// Multi-cycle unsigned shift-add multiplier with start/done handshake; one multiplier bit retired per clock.
// Optional ZERO_BYPASS_EN: a zero operand skips RUN and completes in a single cycle.
module multiplier_controller #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   b;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] next_p;

  // NOTE: always_comb outputs get a value on every path so no latch is inferred.
  always_comb begin
    sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b} : '0);
    next_p = {sum, p[WIDTH-1:1]};
  end

  assign ready = (state == IDLE);
  assign busy  = ~ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      out   <= '0;
      done  <= 1'b0;
      count <= '0;
      p     <= '0;
      // NOTE: b is a pure datapath register, always loaded before use, so it is left unreset.
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
`ifdef ZERO_BYPASS_EN
            if (in1 == '0 || in2 == '0) begin
              out   <= '0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              p     <= {{WIDTH{1'b0}}, in1};
              b     <= in2;
              count <= '0;
              state <= RUN;
            end
`else
            p     <= {{WIDTH{1'b0}}, in1};
            b     <= in2;
            count <= '0;
            state <= RUN;
`endif
          end
        end
        RUN: begin
          p     <= next_p;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            out   <= next_p;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // Completion pulse lasts exactly one cycle; start is not looked at here.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_controller.sv
// Directed self-checking bench for multiplier_controller at WIDTH=32.
module tb_multiplier_controller;

  localparam int W = 32;

  logic           clock;
  logic           reset;
  logic           start;
  logic [W-1:0]   in1;
  logic [W-1:0]   in2;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] out;

  int checks = 0;
  int errors = 0;

  multiplier_controller #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .in1(in1), .in2(in2),
    .ready(ready), .busy(busy), .done(done), .out(out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issues one operation from a negedge where ready=1 and measures, in rising edges after
  // the accepting edge, when done is first seen. acc_busy reports busy right after accept.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] bb,
                        output int lat, output logic [2*W-1:0] res, output logic acc_busy);
    int guard = 0;
    while (!ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    start = 1'b1; in1 = a; in2 = bb;
    @(negedge clock);
    start = 1'b0; in1 = $urandom; in2 = $urandom;
    acc_busy = busy;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    res = out;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (out !== 64'd0)  begin errors++; $display("FAIL reset_out: got %h want 0", out); end
  endtask

  task automatic test_basic();
    int lat; logic [2*W-1:0] res; logic ab;
    run_op(32'd3, 32'd5, lat, res, ab);
    checks++; if (ab !== 1'b1) begin errors++; $display("FAIL basic_accept_busy: got %b want 1", ab); end
    checks++; if (lat != 32) begin errors++; $display("FAIL basic_latency: got %0d want 32", lat); end
    checks++; if (res !== 64'h0000_0000_0000_000F) begin errors++; $display("FAIL basic_out: got %h want f", res); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done: got %b want 0", ready); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b want 1", ready); end
    repeat (3) @(negedge clock);
    checks++; if (out !== 64'h0000_0000_0000_000F) begin errors++; $display("FAIL basic_out_held: got %h want f", out); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [2*W-1:0] res; logic ab;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, ab);
    checks++; if (res !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL max_out: got %h want fffffffe00000001", res); end
    @(negedge clock);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready: got %b want 1", ready); end
    run_op(32'h8000_0000, 32'd2, lat, res, ab);
    checks++; if (ab !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b want 1", ab); end
    checks++; if (lat != 32) begin errors++; $display("FAIL b2b_latency: got %0d want 32", lat); end
    checks++; if (res !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL b2b_out: got %h want 100000000", res); end
    @(negedge clock);
  endtask

  task automatic test_ignore_start();
    int k = 0;
    int pulses = 0;
    start = 1'b1; in1 = 32'd7; in2 = 32'd9;
    @(negedge clock);
    start = 1'b0;
    while (!done && k < 100) begin
      @(negedge clock);
      k++;
      if (k == 10) begin start = 1'b1; in1 = 32'd1; in2 = 32'd1; end
      if (k == 11) start = 1'b0;
    end
    if (done) pulses++;
    checks++; if (k != 32) begin errors++; $display("FAIL ign_latency: got %0d want 32", k); end
    checks++; if (out !== 64'd63) begin errors++; $display("FAIL ign_out: got %0d want 63", out); end
    start = 1'b1; in1 = 32'd1; in2 = 32'd1;
    @(negedge clock);
    start = 1'b0;
    if (done) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL ign_single_pulse: got %0d want 1", pulses); end
    @(negedge clock);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ign_done_start: ready got %b want 1", ready); end
    repeat (35) @(negedge clock);
    checks++; if (out !== 64'd63) begin errors++; $display("FAIL ign_out_held: got %0d want 63", out); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [2*W-1:0] res; logic ab;
    int seen = 0;
    start = 1'b1; in1 = 32'd100; in2 = 32'd200;
    @(negedge clock);
    start = 1'b0;
    repeat (16) @(negedge clock);
    reset = 1'b1; start = 1'b1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", ready); end
    checks++; if (out !== 64'd0) begin errors++; $display("FAIL abort_out: got %h want 0", out); end
    repeat (40) begin
      if (done) seen++;
      @(negedge clock);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    run_op(32'd6, 32'd7, lat, res, ab);
    checks++; if (res !== 64'd42) begin errors++; $display("FAIL abort_then_42: got %0d want 42", res); end
    @(negedge clock);
  endtask

  task automatic test_zero();
    int lat; logic [2*W-1:0] res; logic ab;
    int want_lat;
`ifdef ZERO_BYPASS_EN
    want_lat = 0;
`else
    want_lat = 32;
`endif
    run_op(32'd0, 32'h1234, lat, res, ab);
    checks++; if (res !== 64'd0) begin errors++; $display("FAIL zero_out: got %h want 0", res); end
    checks++; if (lat != want_lat) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, want_lat); end
    @(negedge clock);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL zero_ready_after: got %b want 1", ready); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
